// File: rtl/ticket_arb_pkg.sv
// Shared definitions for the ticket round-robin arbiter: width helpers,
// the queue entry layout and the delivered-ticket counter width.
package ticket_arb_pkg;

  localparam int TICKET_CNT_WIDTH = 16;
  localparam int MAX_DATA_WIDTH   = 64;
  localparam int MAX_SRC_WIDTH    = 4;   // enough for the 16-source maximum

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int src_width(input int ports);
    return (clog2(ports) < 1) ? 1 : clog2(ports);
  endfunction

  // Entries are sized for the largest legal configuration; only the low
  // CTRL_DATA_WIDTH / SRC_WIDTH bits carry information.
  typedef struct packed {
    logic [MAX_DATA_WIDTH-1:0] data;
    logic [MAX_SRC_WIDTH-1:0]  src;
  } ticket_entry_t;

endpackage

// File: rtl/ticket_rr_arbiter_if.sv
// Source-side and consumer-side channels of the ticket arbiter.
interface ticket_rr_arbiter_if
  import ticket_arb_pkg::*;
#(
  parameter int CTRL_DATA_WIDTH = 8,
  parameter int PORTS           = 4
);
  localparam int SRC_WIDTH = src_width(PORTS);

  logic [PORTS*CTRL_DATA_WIDTH-1:0] IN_DATA;
  logic [PORTS-1:0]                 IN_VLD;
  logic [PORTS-1:0]                 IN_RQ;
  logic [CTRL_DATA_WIDTH-1:0]       CTRL_DATA_OUT;
  logic                             CTRL_DATA_OUT_VLD;
  logic                             CTRL_DATA_OUT_RQ;
  logic [SRC_WIDTH-1:0]             CTRL_SRC_OUT;
  logic [TICKET_CNT_WIDTH-1:0]      TICKET_CNT;

  // master: sources plus consumer; slave: the arbiter itself
  modport master (
    output IN_DATA, IN_VLD, CTRL_DATA_OUT_RQ,
    input  IN_RQ, CTRL_DATA_OUT, CTRL_DATA_OUT_VLD, CTRL_SRC_OUT, TICKET_CNT
  );

  modport slave (
    input  IN_DATA, IN_VLD, CTRL_DATA_OUT_RQ,
    output IN_RQ, CTRL_DATA_OUT, CTRL_DATA_OUT_VLD, CTRL_SRC_OUT, TICKET_CNT
  );
endinterface

// File: rtl/ticket_arb_fifo2.sv
// Two-entry ticket queue; the head is always entry 0 and reads as zero
// when the queue is empty.
module ticket_arb_fifo2
  import ticket_arb_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET,
  input  logic          enq,
  input  ticket_entry_t enq_entry,
  input  logic          deq,
  output ticket_entry_t head,
  output logic [1:0]    cnt
);

  ticket_entry_t mem [2];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      // NOTE: the queue storage is reset as well so the head reads zero
      // immediately after reset without relying on the cnt gating alone.
      mem[0] <= '0;
      mem[1] <= '0;
      cnt    <= 2'd0;
    end else begin
      unique case ({enq, deq})
        2'b10: begin
          if (cnt == 2'd0) mem[0] <= enq_entry;
          else             mem[1] <= enq_entry;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          mem[0] <= mem[1];
          mem[1] <= '0;
          cnt    <= cnt - 2'd1;
        end
        // Only reachable at cnt=1: the new ticket becomes the head.
        2'b11: mem[0] <= enq_entry;
        default: ;
      endcase
    end
  end

  assign head = (cnt != 2'd0) ? mem[0] : '0;

endmodule

// File: rtl/ticket_rr_arbiter.sv
// Round-robin grant of PORTS ticket sources into a 2-entry queue feeding
// the splitter control port, with a delivered-ticket counter.
module ticket_rr_arbiter
  import ticket_arb_pkg::*;
#(
  parameter int CTRL_DATA_WIDTH = 8,
  parameter int PORTS           = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  ticket_rr_arbiter_if.slave  bus
);

  localparam int SRC_WIDTH = src_width(PORTS);

  logic [SRC_WIDTH-1:0]        ptr;
  logic [SRC_WIDTH-1:0]        gnt_idx;
  logic                        gnt;
  logic [PORTS-1:0]            rq;
  logic [1:0]                  cnt;
  logic                        deq;
  ticket_entry_t               enq_entry;
  ticket_entry_t               head;
  logic [TICKET_CNT_WIDTH-1:0] ticket_cnt;
  logic                        head_unused_bits;

  // NOTE: every output of this block gets a default first so no path
  // leaves a value held, which would otherwise infer a latch.
  always_comb begin
    int idx;
    gnt     = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (!RESET && cnt != 2'd2) begin
      for (int k = 0; k < PORTS; k++) begin
        idx = (int'(ptr) + k) % PORTS;
        if (!gnt && bus.IN_VLD[idx]) begin
          gnt     = 1'b1;
          gnt_idx = SRC_WIDTH'(idx);
        end
      end
    end
  end

  always_comb begin
    rq = '0;
    if (gnt) rq[gnt_idx] = 1'b1;
  end

  always_comb begin
    enq_entry = '0;
    enq_entry.data[CTRL_DATA_WIDTH-1:0] = bus.IN_DATA[gnt_idx*CTRL_DATA_WIDTH +: CTRL_DATA_WIDTH];
    enq_entry.src[SRC_WIDTH-1:0]        = gnt_idx;
  end

  assign deq = (cnt != 2'd0) && bus.CTRL_DATA_OUT_RQ;

  ticket_arb_fifo2 u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .enq       (gnt),
    .enq_entry (enq_entry),
    .deq       (deq),
    .head      (head),
    .cnt       (cnt)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr        <= '0;
      ticket_cnt <= '0;
    end else begin
      if (gnt) begin
        ptr <= (gnt_idx == SRC_WIDTH'(PORTS - 1)) ? '0 : gnt_idx + SRC_WIDTH'(1);
      end
      if (deq) ticket_cnt <= ticket_cnt + TICKET_CNT_WIDTH'(1);
    end
  end

  assign bus.IN_RQ             = rq;
  assign bus.CTRL_DATA_OUT_VLD = (cnt != 2'd0);
  assign bus.CTRL_DATA_OUT     = head.data[CTRL_DATA_WIDTH-1:0];
  assign bus.CTRL_SRC_OUT      = head.src[SRC_WIDTH-1:0];
  assign bus.TICKET_CNT        = ticket_cnt;

  // Upper entry bits exist only for the widest configuration.
  assign head_unused_bits = ^head;

endmodule

// File: tb/tb_ticket_rr_arbiter.sv
// Directed bench for ticket_rr_arbiter: a queue-based reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_ticket_rr_arbiter;

  localparam int W     = 8;
  localparam int PORTS = 4;

  logic CLK = 1'b0;
  logic RESET;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 CLK = ~CLK;

  ticket_rr_arbiter_if #(.CTRL_DATA_WIDTH(W), .PORTS(PORTS)) bus ();

  ticket_rr_arbiter #(.CTRL_DATA_WIDTH(W), .PORTS(PORTS)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a queue of {data, src}, the next-priority source and a
  // 16-bit delivery count.
  logic [W-1:0] mq_data[$];
  int           mq_src[$];
  int           m_ptr = 0;
  logic [15:0]  m_tcnt = '0;
  bit           model_live = 0;

  function automatic int model_pick();
    if (RESET || mq_src.size() >= 2) return -1;
    for (int k = 0; k < PORTS; k++) begin
      if (bus.IN_VLD[(m_ptr + k) % PORTS]) return (m_ptr + k) % PORTS;
    end
    return -1;
  endfunction

  always @(posedge CLK) begin
    int g;
    bit d;
    if (RESET) begin
      mq_data.delete();
      mq_src.delete();
      m_ptr      = 0;
      m_tcnt     = '0;
      model_live = 1;
    end else if (model_live) begin
      g = model_pick();
      d = (mq_src.size() > 0) && bus.CTRL_DATA_OUT_RQ;
      if (d) begin
        void'(mq_data.pop_front());
        void'(mq_src.pop_front());
        m_tcnt = m_tcnt + 16'd1;
      end
      if (g >= 0) begin
        mq_data.push_back(bus.IN_DATA[g*W +: W]);
        mq_src.push_back(g);
        m_ptr = (g + 1) % PORTS;
      end
    end
  end

  always @(negedge CLK) begin
    int g;
    if (model_live) begin
      g = model_pick();
      check("model_in_rq", bus.IN_RQ, (g < 0) ? 0 : (1 << g));
      check("model_vld", bus.CTRL_DATA_OUT_VLD, mq_src.size() > 0);
      check("model_data", bus.CTRL_DATA_OUT, (mq_src.size() > 0) ? mq_data[0] : 0);
      check("model_src", bus.CTRL_SRC_OUT, (mq_src.size() > 0) ? mq_src[0] : 0);
      check("model_tcnt", bus.TICKET_CNT, m_tcnt);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    RESET                = 1'b1;
    bus.IN_DATA          = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.IN_VLD           = '0;
    bus.CTRL_DATA_OUT_RQ = 1'b0;

    // Reset and idle
    repeat (2) tick();
    @(negedge CLK);
    check("rst_in_rq", bus.IN_RQ, 0);
    check("rst_vld", bus.CTRL_DATA_OUT_VLD, 0);
    bus.IN_VLD = 4'hF;
    @(negedge CLK);
    check("rst_forced_in_rq", bus.IN_RQ, 0);
    tick();
    RESET      = 1'b0;
    bus.IN_VLD = '0;
    @(negedge CLK);
    check("idle_in_rq", bus.IN_RQ, 0);
    check("idle_vld", bus.CTRL_DATA_OUT_VLD, 0);
    check("idle_tcnt", bus.TICKET_CNT, 0);
    tick();

    // All sources valid, consumer always ready: grants rotate 0..3
    do_reset();
    bus.IN_VLD           = 4'hF;
    bus.CTRL_DATA_OUT_RQ = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      check("rr_in_rq", bus.IN_RQ, 1 << (c % 4));
      check("rr_vld", bus.CTRL_DATA_OUT_VLD, c > 0);
      if (c > 0) begin
        check("rr_data", bus.CTRL_DATA_OUT, 8'h10 + ((c - 1) % 4));
        check("rr_src", bus.CTRL_SRC_OUT, (c - 1) % 4);
      end
      check("rr_tcnt", bus.TICKET_CNT, (c > 0) ? c - 1 : 0);
      tick();
    end

    // Consumer stalled, sources 0 and 2 valid: fill to 2, then drain
    bus.IN_VLD           = '0;
    bus.CTRL_DATA_OUT_RQ = 1'b0;
    do_reset();
    bus.IN_VLD = 4'b0101;
    @(negedge CLK); check("fill_rq0", bus.IN_RQ, 4'b0001); tick();
    @(negedge CLK); check("fill_rq1", bus.IN_RQ, 4'b0100);
    check("fill_src1", bus.CTRL_SRC_OUT, 0); tick();
    @(negedge CLK); check("full_rq", bus.IN_RQ, 0);
    check("full_vld", bus.CTRL_DATA_OUT_VLD, 1); tick();
    bus.CTRL_DATA_OUT_RQ = 1'b1;
    @(negedge CLK); check("drain_rq0", bus.IN_RQ, 0);
    check("drain_src0", bus.CTRL_SRC_OUT, 0);
    check("drain_data0", bus.CTRL_DATA_OUT, 8'h10); tick();
    @(negedge CLK); check("resume_rq", bus.IN_RQ, 4'b0001);
    check("drain_src1", bus.CTRL_SRC_OUT, 2);
    check("drain_data1", bus.CTRL_DATA_OUT, 8'h12); tick();
    @(negedge CLK); check("drain_src2", bus.CTRL_SRC_OUT, 0); tick();

    // Sparse: only source 3 valid while ptr=1
    bus.IN_VLD = '0;
    do_reset();
    bus.IN_VLD = 4'b0001;
    tick();
    bus.IN_VLD = 4'b1000;
    @(negedge CLK); check("sparse_rq", bus.IN_RQ, 4'b1000); tick();
    bus.IN_VLD = 4'hF;
    @(negedge CLK); check("sparse_ptr_wrap", bus.IN_RQ, 4'b0001);
    check("sparse_src", bus.CTRL_SRC_OUT, 3); tick();

    // Delivery counter wrap after 65537 tickets
    do_reset();
    bus.IN_VLD           = 4'hF;
    bus.CTRL_DATA_OUT_RQ = 1'b1;
    repeat (65538) @(posedge CLK);
    @(negedge CLK);
    check("tcnt_wrap", bus.TICKET_CNT, 16'h0001);
    #1;

    // Reset pulse with a full queue; held ticket re-accepted afterwards
    bus.IN_VLD           = '0;
    bus.CTRL_DATA_OUT_RQ = 1'b0;
    tick();
    do_reset();
    bus.IN_VLD = 4'b0101;
    tick();
    tick();
    @(negedge CLK); check("pre_rst_full_rq", bus.IN_RQ, 0); tick();
    RESET = 1'b1;
    @(negedge CLK); check("mid_rst_vld", bus.CTRL_DATA_OUT_VLD, 1); tick();
    RESET = 1'b0;
    @(negedge CLK);
    check("post_rst_vld", bus.CTRL_DATA_OUT_VLD, 0);
    check("post_rst_data", bus.CTRL_DATA_OUT, 0);
    check("post_rst_rq", bus.IN_RQ, 4'b0001);
    tick();
    @(negedge CLK);
    check("reaccept_vld", bus.CTRL_DATA_OUT_VLD, 1);
    check("reaccept_data", bus.CTRL_DATA_OUT, 8'h10);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
